// File: rtl/sensor_stream_parser.sv
// Byte-wise parser for the iRobot sensor stream frame [HDR, N, (ID, data...)*, CSUM].
// Checksum-good frames commit bumps/distance/angle; bad or stalled frames are dropped and counted.
module sensor_stream_parser #(
  parameter logic [7:0] HEADER  = 8'd19,
  parameter int         TIMEOUT = 100000,
  parameter int         TO_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [7:0]  bumps,
  output logic [15:0] distance,
  output logic [15:0] angle,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  localparam logic [1:0] K_BUMP = 2'd0;
  localparam logic [1:0] K_DIST = 2'd1;
  localparam logic [1:0] K_ANG  = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]         state_q, state_d;
  logic [7:0]         acc_q, acc_d;
  logic [7:0]         rem_q, rem_d;
  logic [1:0]         need_q, need_d;
  logic [1:0]         kind_q, kind_d;
  logic [2:0]         seen_q, seen_d;
  logic [7:0]         sh_bumps_q, sh_bumps_d;
  logic signed [15:0] sh_dist_q, sh_dist_d;
  logic signed [15:0] sh_ang_q, sh_ang_d;
  logic [7:0]         bumps_q, bumps_d;
  logic signed [15:0] dist_q, dist_d;
  logic signed [15:0] ang_q, ang_d;
  logic               fv_q, fv_d;
  logic               fe_q, fe_d;
  logic [7:0]         err_q, err_d;
  logic [TO_W-1:0]    to_q, to_d;

  logic [7:0] sum;
  logic [1:0] need_n;
  logic [1:0] kind_n;
  logic       id_bad;
  logic       bad;

  assign sum = acc_q + byte_in;

  always_comb begin
    need_n = 2'd0;
    kind_n = K_BUMP;
    id_bad = 1'b0;
    case (byte_in)
      8'd7:    begin need_n = 2'd1; kind_n = K_BUMP; end
      8'd19:   begin need_n = 2'd2; kind_n = K_DIST; end
      8'd20:   begin need_n = 2'd2; kind_n = K_ANG;  end
      default: id_bad = 1'b1;
    endcase
    // rem_q >= 1 here, so "need > rem-1" is the same as "rem <= need".
    if (rem_q <= {6'd0, need_n}) id_bad = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    need_d     = need_q;
    kind_d     = kind_q;
    seen_d     = seen_q;
    sh_bumps_d = sh_bumps_q;
    sh_dist_d  = sh_dist_q;
    sh_ang_d   = sh_ang_q;
    bumps_d    = bumps_q;
    dist_d     = dist_q;
    ang_d      = ang_q;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    err_d      = err_q;
    bad        = 1'b0;
    to_d       = (byte_valid || state_q == S_HDR) ? '0 : to_q + 1'b1;

    if (byte_valid) begin
      case (state_q)
        S_HDR: begin
          if (byte_in == HEADER) begin
            state_d = S_LEN;
            acc_d   = HEADER;
            seen_d  = 3'b000;
          end
        end
        S_LEN: begin
          acc_d   = sum;
          rem_d   = byte_in;
          state_d = (byte_in == 8'd0) ? S_CSUM : S_ID;
        end
        S_ID: begin
          acc_d = sum;
          if (id_bad) begin
            bad = 1'b1;
          end else begin
            rem_d   = rem_q - 8'd1;
            need_d  = need_n;
            kind_d  = kind_n;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          acc_d  = sum;
          rem_d  = rem_q - 8'd1;
          need_d = need_q - 2'd1;
          seen_d[kind_q] = 1'b1;
          // Multi-byte values arrive high byte first, so shift left.
          case (kind_q)
            K_BUMP:  sh_bumps_d = byte_in;
            K_DIST:  sh_dist_d  = {sh_dist_q[7:0], byte_in};
            default: sh_ang_d   = {sh_ang_q[7:0], byte_in};
          endcase
          if (need_q == 2'd1) state_d = (rem_q == 8'd1) ? S_CSUM : S_ID;
        end
        S_CSUM: begin
          state_d = S_HDR;
          if (sum == 8'd0) begin
            fv_d = 1'b1;
            if (seen_q[K_BUMP]) bumps_d = sh_bumps_q;
            if (seen_q[K_DIST]) dist_d  = sh_dist_q;
            if (seen_q[K_ANG])  ang_d   = sh_ang_q;
          end else begin
            bad = 1'b1;
          end
        end
        default: state_d = S_HDR;
      endcase
    end else if (state_q != S_HDR && to_q == TO_LAST) begin
      bad = 1'b1;
    end

    if (bad) begin
      state_d = S_HDR;
      seen_d  = 3'b000;
      fe_d    = 1'b1;
      err_d   = sat_inc(err_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HDR;
      acc_q      <= '0;
      rem_q      <= '0;
      need_q     <= '0;
      kind_q     <= K_BUMP;
      seen_q     <= '0;
      sh_bumps_q <= '0;
      sh_dist_q  <= '0;
      sh_ang_q   <= '0;
      bumps_q    <= '0;
      dist_q     <= '0;
      ang_q      <= '0;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
      err_q      <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      need_q     <= need_d;
      kind_q     <= kind_d;
      seen_q     <= seen_d;
      sh_bumps_q <= sh_bumps_d;
      sh_dist_q  <= sh_dist_d;
      sh_ang_q   <= sh_ang_d;
      bumps_q    <= bumps_d;
      dist_q     <= dist_d;
      ang_q      <= ang_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
      err_q      <= err_d;
      to_q       <= to_d;
    end
  end

  assign bumps       = bumps_q;
  assign distance    = dist_q;
  assign angle       = ang_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign err_cnt     = err_q;
  assign busy        = (state_q != S_HDR);

endmodule

// File: tb/tb_sensor_stream_parser.sv
// Scoreboard bench for sensor_stream_parser: directed frames push expected results,
// a negedge monitor pops and compares on every frame_valid / frame_err pulse.
module tb_sensor_stream_parser;

  localparam int TIMEOUT = 40;
  localparam int TO_W    = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic [7:0]  bumps;
  logic [15:0] distance;
  logic [15:0] angle;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;

  sensor_stream_parser #(.HEADER(8'd19), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_in(byte_in),
    .bumps(bumps), .distance(distance), .angle(angle),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [7:0]  b;
    logic [15:0] d;
    logic [15:0] a;
    logic [7:0]  e;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  fr[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  m_b = 8'h00;
  logic [15:0] m_d = 16'h0000;
  logic [15:0] m_a = 16'h0000;
  logic [7:0]  m_e = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic exp_ok(input logic [7:0] b, input logic [15:0] d, input logic [15:0] a);
    exp_t x;
    m_b = b; m_d = d; m_a = a;
    x.is_err = 1'b0; x.b = m_b; x.d = m_d; x.a = m_a; x.e = m_e;
    sbq.push_back(x);
  endtask

  task automatic exp_bad();
    exp_t x;
    m_e = (m_e == 8'hFF) ? 8'hFF : m_e + 8'd1;
    x.is_err = 1'b1; x.b = m_b; x.d = m_d; x.a = m_a; x.e = m_e;
    sbq.push_back(x);
  endtask

  // Called at a negedge; returns at the next negedge with the byte consumed.
  task automatic send(input logic [7:0] v);
    byte_valid = 1'b1;
    byte_in    = v;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_fr();
    foreach (fr[i]) send(fr[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    m_b = 8'h00; m_d = 16'h0000; m_a = 16'h0000; m_e = 8'h00;
  endtask

  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got fv=%0b fe=%0b, want none (t=%0t)", frame_valid, frame_err, $time);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("event_kind", {31'd0, frame_err}, {31'd0, x.is_err});
        chk("excl", {31'd0, frame_valid & frame_err}, 32'd0);
        chk("bumps", {24'd0, bumps}, {24'd0, x.b});
        chk("distance", {16'd0, distance}, {16'd0, x.d});
        chk("angle", {16'd0, angle}, {16'd0, x.a});
        chk("err_cnt", {24'd0, err_cnt}, {24'd0, x.e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    rst = 1'b0;
    chk("rst_bumps", {24'd0, bumps}, 32'd0);
    chk("rst_distance", {16'd0, distance}, 32'd0);
    chk("rst_angle", {16'd0, angle}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulses", {30'd0, frame_valid, frame_err}, 32'd0);

    // Bad checksum from reset: outputs stay 0, one error.
    fr = '{8'h13, 8'h05, 8'h07, 8'h03, 8'h13, 8'hFF, 8'hF6, 8'hD7};
    exp_bad();
    send_fr();
    idle(2);
    do_reset();
    chk("err_cnt_cleared", {24'd0, err_cnt}, 32'd0);

    // Good frame: bumps 03, distance -10.
    fr = '{8'h13, 8'h05, 8'h07, 8'h03, 8'h13, 8'hFF, 8'hF6, 8'hD6};
    exp_ok(8'h03, 16'hFFF6, 16'h0000);
    send_fr();
    idle(2);

    // Empty frame commits nothing new; then unknown ID 2A drops the frame.
    fr = '{8'h13, 8'h00, 8'hED};
    exp_ok(8'h03, 16'hFFF6, 16'h0000);
    send_fr();
    fr = '{8'h13, 8'h02, 8'h2A};
    exp_bad();
    send_fr();
    chk("idle_after_bad_id", {31'd0, busy}, 32'd0);
    send(8'h01);
    send(8'h02);
    chk("ignored_tail", {31'd0, busy}, 32'd0);

    // ID 19 with too little length left, then a normal frame recovers.
    fr = '{8'h13, 8'h01, 8'h13};
    exp_bad();
    send_fr();
    fr = '{8'h13, 8'h05, 8'h07, 8'h03, 8'h13, 8'hFF, 8'hF6, 8'hD6};
    exp_ok(8'h03, 16'hFFF6, 16'h0000);
    send_fr();
    idle(2);

    // Timeout: error exactly TIMEOUT idle cycles after the last byte.
    fr = '{8'h13, 8'h05, 8'h07};
    exp_bad();
    send_fr();
    idle(TIMEOUT - 1);
    chk("pre_expiry_err", {31'd0, frame_err}, 32'd0);
    chk("pre_expiry_busy", {31'd0, busy}, 32'd0 + 1);
    idle(1);
    chk("expiry_err", {31'd0, frame_err}, 32'd1);
    chk("expiry_busy", {31'd0, busy}, 32'd0);

    // Gap of TIMEOUT-2 idle cycles, then a byte coincident with expiry: both survive.
    exp_ok(8'h03, 16'hFFF6, 16'h0000);
    fr = '{8'h13, 8'h05, 8'h07};
    send_fr();
    idle(TIMEOUT - 2);
    fr = '{8'h03, 8'h13, 8'hFF, 8'hF6, 8'hD6};
    send_fr();
    exp_ok(8'h03, 16'hFFF6, 16'h0000);
    fr = '{8'h13, 8'h05, 8'h07};
    send_fr();
    idle(TIMEOUT - 1);
    fr = '{8'h03, 8'h13, 8'hFF, 8'hF6, 8'hD6};
    send_fr();
    idle(2);

    // Duplicate ID 7: last value wins, distance/angle keep their old values.
    fr = '{8'h13, 8'h04, 8'h07, 8'h01, 8'h07, 8'h02, 8'hD8};
    exp_ok(8'h02, 16'hFFF6, 16'h0000);
    send_fr();
    idle(2);

    // err_cnt saturates at 255.
    for (int k = 0; k < 256; k++) begin
      fr = '{8'h13, 8'h00, 8'h00};
      exp_bad();
      send_fr();
    end
    idle(2);
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

    // Reset mid-frame: silent abandon, outputs and err_cnt back to 0.
    fr = '{8'h13, 8'h05, 8'h07};
    send_fr();
    do_reset();
    chk("midrst_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_bumps", {24'd0, bumps}, 32'd0);
    chk("midrst_distance", {16'd0, distance}, 32'd0);
    chk("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);

    // Angle-only frame; checksum 7C makes 13+03+14+00+5A+7C wrap to 00.
    fr = '{8'h13, 8'h03, 8'h14, 8'h00, 8'h5A, 8'h7C};
    exp_ok(8'h00, 16'h0000, 16'h005A);
    send_fr();
    idle(5);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
